tdr_ring_seq: RTL and testbench

Sequencer for the time-domain register's ring oscillator. It arms the oscillator, enables it for a programmed window of clock cycles, and counts the oscillator's rising edges through a synchroniser. It then freezes the ring with the read-enable and drains the synchroniser, and reports the edge count to the register read path. It sits between the register-file control logic and the ring oscillator's control inputs (rstb, tsc_i, carry_b, RE).

---
 rtl/tdr_ring_seq.sv | 154 +++++++++++++++
 tb/tb_tdr_ring_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdr_ring_seq.sv
`timescale 1ns/1ps
// Purpose: sequences the TDR ring oscillator (arm, run window, freeze/drain) and counts its synchronised rising edges.
// Latency: done_o pulses win_len+SYNC_STAGES+3 cycles after an accepted start (1 cycle for a zero window).
// Backpressure: none; start_i is ignored while busy (no queuing), abort_i returns to IDLE without done_o.
module tdr_ring_seq #(
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIN_W-1:0] win_len_i,
    input  logic             ring_i,
    output logic             ring_rstb_o,
    output logic             tsc_o,
    output logic             carry_b_o,
    output logic             re_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o
);

    localparam int HOLD_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [WIN_W-1:0]       win_cnt;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [CNT_W-1:0]       edge_cnt;
    logic [CNT_W-1:0]       edge_cnt_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_prev;
    logic                   rise;
    logic                   counting;
    logic                   accept;
    logic                   ovf_set;

    // Rising edge seen at the output of the synchroniser.
    assign rise     = sync[SYNC_STAGES-1] & ~sync_prev;
    // HOLD keeps counting so edges already inside the synchroniser are not lost.
    assign counting = (state == S_RUN) || (state == S_HOLD);
    assign accept   = (state == S_IDLE) && start_i;

    // Saturating edge counter update and overflow detection.
    always_comb begin
        edge_cnt_nxt = edge_cnt;
        ovf_set      = 1'b0;
        if (counting && rise) begin
            if (&edge_cnt) begin
                ovf_set = 1'b1;
            end else begin
                edge_cnt_nxt = edge_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state decode; abort overrides any transition out of ARM/RUN/HOLD.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = (win_len_i == '0) ? S_DONE : S_ARM;
                end
            end
            S_ARM:  state_nxt = S_RUN;
            S_RUN:  if (win_cnt == WIN_W'(1)) state_nxt = S_HOLD;
            S_HOLD: if (hold_cnt == '0) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort_i && ((state == S_ARM) || (state == S_RUN) || (state == S_HOLD))) begin
            state_nxt = S_IDLE;
        end
    end

    // ring_i synchroniser plus one delay flop for edge detection; runs in every state.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            sync      <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], ring_i};
            sync_prev <= sync[SYNC_STAGES-1];
        end
    end

    // FSM state, counters and outputs; outputs are registered from the next state so they never glitch.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state       <= S_IDLE;
            win_cnt     <= '0;
            hold_cnt    <= '0;
            edge_cnt    <= '0;
            count_o     <= '0;
            ovf_o       <= 1'b0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
            ring_rstb_o <= 1'b0;
            tsc_o       <= 1'b0;
            carry_b_o   <= 1'b0;
            re_o        <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                win_cnt <= win_len_i;
            end else if (state == S_RUN) begin
                win_cnt <= win_cnt - WIN_W'(1);
            end

            // Loaded on HOLD entry so HOLD spans SYNC_STAGES+1 cycles.
            if ((state_nxt == S_HOLD) && (state != S_HOLD)) begin
                hold_cnt <= HOLD_W'(SYNC_STAGES);
            end else if (state == S_HOLD) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end

            if (accept) begin
                edge_cnt <= '0;
                ovf_o    <= 1'b0;
            end else begin
                edge_cnt <= edge_cnt_nxt;
                if (ovf_set) begin
                    ovf_o <= 1'b1;
                end
            end

            // Include any edge landing in the final HOLD cycle in the reported count.
            if (state_nxt == S_DONE) begin
                count_o <= (state == S_IDLE) ? '0 : edge_cnt_nxt;
            end

            done_o      <= (state_nxt == S_DONE);
            busy_o      <= (state_nxt != S_IDLE);
            ring_rstb_o <= (state_nxt == S_ARM) || (state_nxt == S_RUN) || (state_nxt == S_HOLD);
            tsc_o       <= (state_nxt == S_RUN);
            carry_b_o   <= (state_nxt == S_RUN) || (state_nxt == S_HOLD);
            re_o        <= (state_nxt == S_HOLD);
        end
    end

endmodule

// File: tb/tb_tdr_ring_seq.sv
`timescale 1ns/1ps
// Purpose: self-checking bench for tdr_ring_seq with a gated ring model and a done_o scoreboard.
// Latency: expected done cycle is recorded per start and compared when done_o is seen.
// Backpressure: n/a; every wait on the DUT is bounded by a cycle budget.
module tb_tdr_ring_seq;

    typedef struct {
        int cnt;
        int ovf;
        int cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    // default-width instance
    logic        start0 = 1'b0, abort0 = 1'b0, ring0 = 1'b0;
    logic [11:0] win0 = '0;
    logic        ring_rstb0, tsc0, carry_b0, re0, busy0, done0, ovf0;
    logic [15:0] count0;
    int          k0 = 0;
    exp_t        q0[$];

    // narrow-counter instance for saturation
    logic        start1 = 1'b0, abort1 = 1'b0, ring1 = 1'b0;
    logic [11:0] win1 = '0;
    logic        ring_rstb1, tsc1, carry_b1, re1, busy1, done1, ovf1;
    logic [3:0]  count1;
    int          k1 = 0;
    exp_t        q1[$];

    logic        tsc_seen = 1'b0;

    tdr_ring_seq u_dut (
        .clk(clk), .rstb(rstb), .start_i(start0), .abort_i(abort0), .win_len_i(win0),
        .ring_i(ring0), .ring_rstb_o(ring_rstb0), .tsc_o(tsc0), .carry_b_o(carry_b0),
        .re_o(re0), .busy_o(busy0), .done_o(done0), .count_o(count0), .ovf_o(ovf0)
    );

    tdr_ring_seq #(.CNT_W(4)) u_sat (
        .clk(clk), .rstb(rstb), .start_i(start1), .abort_i(abort1), .win_len_i(win1),
        .ring_i(ring1), .ring_rstb_o(ring_rstb1), .tsc_o(tsc1), .carry_b_o(carry_b1),
        .re_o(re1), .busy_o(busy1), .done_o(done1), .count_o(count1), .ovf_o(ovf1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Ring model: enabled only while running; rises in enabled cycles 2, 6, 10, ...
    always @(negedge clk) begin
        if (tsc0 & carry_b0 & ~re0) begin
            k0 = k0 + 1;
            ring0 = ((k0 % 4) >= 2);
        end else begin
            k0 = 0;
            ring0 = 1'b0;
        end
        if (tsc1 & carry_b1 & ~re1) begin
            k1 = k1 + 1;
            ring1 = ((k1 % 4) >= 2);
        end else begin
            k1 = 0;
            ring1 = 1'b0;
        end
        if (tsc0) tsc_seen = 1'b1;
    end

    // Scoreboard for the default instance.
    always @(negedge clk) begin
        if (rstb && done0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk("unexpected_done0", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("count0", int'(count0), e.cnt);
                chk("ovf0", int'(ovf0), e.ovf);
                chk("done0_cycle", cyc, e.cyc);
            end
        end
    end

    // Scoreboard for the saturation instance.
    always @(negedge clk) begin
        if (rstb && done1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("unexpected_done1", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("count1", int'(count1), e.cnt);
                chk("ovf1", int'(ovf1), e.ovf);
                chk("done1_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic int exp_lat(input int w);
        return (w == 0) ? 1 : w + 2 + 3;
    endfunction

    // Pulses start for one cycle and records what the DUT must report.
    task automatic do_start(input int sel, input int w, input int cnt, input int ovf);
        exp_t e;
        @(posedge clk); #1;
        e.cnt = cnt;
        e.ovf = ovf;
        e.cyc = cyc + exp_lat(w);
        if (sel == 0) begin
            start0 = 1'b1; win0 = 12'(w); q0.push_back(e);
        end else begin
            start1 = 1'b1; win1 = 12'(w); q1.push_back(e);
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Waits for the scoreboard to drain, then checks busy dropped the following cycle.
    task automatic wait_done(input int sel, input string tag);
        int n;
        n = (sel == 0) ? q0.size() : q1.size();
        for (int i = 0; i < 3000 && n > 0; i++) begin
            @(posedge clk);
            n = (sel == 0) ? q0.size() : q1.size();
        end
        chk({tag, "_timeout"}, n, 0);
        @(negedge clk);
        chk({tag, "_busy_after"}, (sel == 0) ? int'(busy0) : int'(busy1), 0);
    endtask

    task automatic check_idle0(input string tag, input int cnt);
        chk({tag, "_ring_rstb"}, int'(ring_rstb0), 0);
        chk({tag, "_tsc"}, int'(tsc0), 0);
        chk({tag, "_carry_b"}, int'(carry_b0), 0);
        chk({tag, "_re"}, int'(re0), 0);
        chk({tag, "_busy"}, int'(busy0), 0);
        chk({tag, "_done"}, int'(done0), 0);
        chk({tag, "_count"}, int'(count0), cnt);
        chk({tag, "_ovf"}, int'(ovf0), 0);
    endtask

    initial begin
        int base;
        // Reset state
        rstb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle0("reset", 0);
        chk("reset_sat_count", int'(count1), 0);
        rstb = 1'b1;
        repeat (2) @(posedge clk);

        // Zero window: immediate done, ring never enabled
        tsc_seen = 1'b0;
        do_start(0, 0, 0, 0);
        wait_done(0, "zero");
        chk("zero_tsc_seen", int'(tsc_seen), 0);

        // Basic count
        do_start(0, 40, 10, 0);
        wait_done(0, "basic");

        // Saturation then a clean run clearing ovf
        do_start(1, 200, 15, 1);
        wait_done(1, "sat");
        do_start(1, 8, 2, 0);
        wait_done(1, "sat_clear");

        // Abort in RUN cycle 5 with a start held during RUN
        @(posedge clk); #1;
        start0 = 1'b1; win0 = 12'd40;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (2) @(posedge clk); #1;
        start0 = 1'b1;
        chk("abort_in_run_tsc", int'(tsc0), 1);
        repeat (3) @(posedge clk); #1;
        start0 = 1'b0; abort0 = 1'b1;
        @(posedge clk); #1;
        abort0 = 1'b0;
        check_idle0("abort", 10);
        repeat (5) @(posedge clk); #1;
        chk("abort_stays_idle", int'(busy0), 0);

        // Reset in HOLD
        @(posedge clk); #1;
        start0 = 1'b1; win0 = 12'd40;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int i = 0; i < 200 && re0 !== 1'b1; i++) @(negedge clk);
        chk("hold_reached", int'(re0), 1);
        @(posedge clk); #1;
        rstb = 1'b0;
        @(posedge clk); #1;
        check_idle0("hold_reset", 0);
        rstb = 1'b1;
        do_start(0, 40, 10, 0);
        wait_done(0, "after_reset");

        // Back-to-back with start held high: one acceptance every 46 cycles
        @(posedge clk); #1;
        base = cyc;
        for (int r = 0; r < 3; r++) begin
            exp_t e;
            e.cnt = 10;
            e.ovf = 0;
            e.cyc = base + 45 + 46 * r;
            q0.push_back(e);
        end
        start0 = 1'b1; win0 = 12'd40;
        repeat (137) @(posedge clk);
        #1;
        start0 = 1'b0;
        wait_done(0, "b2b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
